// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Two requesters share one 8-bit adder. A round-robin grant picks which
// requester may issue, and the result lands in a one-deep response register
// tagged with the requester id. A saturating counter tracks accepted
// operations whose result overflowed in signed arithmetic.
//
// Handshake and timing:
//  - A requester is ready whenever the response slot is free and the
//    requester holds the grant. The response slot is free when it is empty or
//    being drained this cycle.
//  - The result is registered on the accepting edge, so it appears one cycle
//    after acceptance. One operation can be accepted every cycle.
//  - Neither requester is ready while rst_n is low.
//  - Reset drops any pending response.
module adder_share_arbiter #(
  parameter logic FIRST_PRIO = 1'b0,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Shared adder datapath: returns {signed overflow, carry-out, sum}.
  // Signed overflow occurs when both operands have the same sign and the
  // sum's sign differs from it.
  function automatic logic [9:0] add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic       ovf;
    s   = {1'b0, a} + {1'b0, b};
    ovf = (a[7] == b[7]) && (s[7] != a[7]);
    return {ovf, s};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic             prio_r;
  logic             grant_s;
  logic             slot_free_s;
  logic             accept_s;
  logic [7:0]       op_a_s;
  logic [7:0]       op_b_s;
  logic [9:0]       res_s;
  logic             rsp_id_r;
  logic [7:0]       rsp_sum_r;
  logic             rsp_cout_r;
  logic             rsp_ovf_r;
  logic [CNT_W-1:0] ovf_cnt_r;

  // Grant and handshake.
  // A lone valid requester wins. When both requesters are valid, prio decides.
  // With nobody valid, the grant rests on requester 0.
  always_comb begin
    slot_free_s = (state_r == EMPTY) | rsp_ready;
    grant_s     = req1_valid & (~req0_valid | prio_r);
    req0_ready  = rst_n & slot_free_s & ~grant_s;
    req1_ready  = rst_n & slot_free_s & grant_s;
    accept_s    = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    op_a_s      = grant_s ? req1_a : req0_a;
    op_b_s      = grant_s ? req1_b : req0_b;
    res_s       = add8(op_a_s, op_b_s);
  end

  // Next-state logic for the response slot.
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_s = FULL;
        end else begin
          state_s = EMPTY;
        end
      end
      FULL: begin
        if (accept_s) begin
          state_s = FULL;
        end else if (rsp_ready) begin
          state_s = EMPTY;
        end else begin
          state_s = FULL;
        end
      end
      default: state_s = EMPTY;
    endcase
  end

  // State register and round-robin pointer.
  // After an accept, priority passes to the requester that did not win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      prio_r  <= FIRST_PRIO;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        prio_r <= ~grant_s;
      end
    end
  end

  // Response payload: load on accept, otherwise hold stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_r   <= 1'b0;
      rsp_sum_r  <= 8'h00;
      rsp_cout_r <= 1'b0;
      rsp_ovf_r  <= 1'b0;
    end else if (accept_s) begin
      rsp_id_r   <= grant_s;
      rsp_sum_r  <= res_s[7:0];
      rsp_cout_r <= res_s[8];
      rsp_ovf_r  <= res_s[9];
    end
  end

  // Saturating overflow event counter.
  // A clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      ovf_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s && res_s[9] && (ovf_cnt_r != CNT_MAX)) begin
      ovf_cnt_r <= ovf_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rsp_valid = (state_r == FULL);
  assign rsp_id    = rsp_id_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_cout  = rsp_cout_r;
  assign rsp_ovf   = rsp_ovf_r;
  assign ovf_cnt   = ovf_cnt_r;

endmodule
